alu_mdu_controller: RTL and testbench
=====================================

ALU_MDU_CONTROLLER -- requirements
Module: alu_mdu_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-005 SHALL have port Funct7  input  7  instruction bits 31:25.
REQ-006 SHALL have port Funct3  input  3  instruction bits 14:12.
REQ-007 SHALL have port IsRType  input  1  high for R-type, low for I-type.
REQ-008 SHALL have ports SrcA, SrcB  input  WIDTH  operands for multiply/divide.
REQ-009 SHALL have port in_valid  input  1  request valid.
REQ-010 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready both high.
REQ-011 SHALL have port Operation  output  4  ALU operation select (combinational).
REQ-012 SHALL have port BranchInvert  output  1  invert ALU compare result (Funct3[0] when ALUOp=01, else 0).
REQ-013 SHALL have port Stall  output  1  high while a multiply/divide is in progress.
REQ-014 SHALL have ports out_valid  output  1  and MduResult  output  WIDTH  multiply/divide result.

Function
REQ-015 SHALL decode Operation: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010, CMPEQ 1100, CMPLT 1101, CMPLTU 1110.
REQ-016 SHALL map ALUOp=00 -> ADD; ALUOp=11 -> PASSB; ALUOp=01 -> Funct3[2:1] 00 CMPEQ, 10 CMPLT, 11 CMPLTU, 01 ADD.
REQ-017 SHALL map ALUOp=10 by Funct3; Funct3=000 gives SUB only if IsRType and Funct7=0100000; Funct3=101 gives SRA if Funct7=0100000, else SRL.
REQ-018 SHALL classify as MDU op: ALUOp=10, IsRType=1, Funct7=0000001; Operation then ADD (don't-care for ALU).
REQ-019 SHALL hold in_ready=1 only in IDLE; non-MDU requests complete combinationally, no state change.
REQ-020 SHALL implement FSM IDLE -> BUSY (MDU accept) -> DONE (after WIDTH iterations) -> IDLE (next cycle).
REQ-021 SHALL latch SrcA, SrcB, Funct3 at accept; later input changes SHALL not affect the operation.
REQ-022 SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per BUSY cycle, exactly WIDTH BUSY cycles.
REQ-023 SHALL compute by Funct3: 000 MUL low, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high, 100 DIV, 101 DIVU, 110 REM, 111 REMU; signed divide truncates toward zero, remainder takes dividend sign.
REQ-024 SHALL assert out_valid for exactly one cycle (DONE); MduResult SHALL hold its value until the next DONE.
REQ-025 SHALL, for accept at edge N, place DONE in the cycle after edge N+WIDTH+1 (latency WIDTH+1 cycles).
REQ-026 SHALL drive Stall=1 in BUSY and in the accept cycle (MDU op and in_valid), 0 in IDLE otherwise and in DONE.
REQ-027 SHALL on divisor zero skip BUSY (IDLE -> DONE): DIV/DIVU all-ones, REM/REMU dividend.
REQ-028 SHALL on DIV/REM with dividend = most-negative and divisor = -1 skip BUSY: DIV most-negative, REM zero.
REQ-029 SHALL ignore in_valid in BUSY and DONE (no queuing).

Reset
REQ-030 SHALL on reset, including mid-operation: FSM IDLE, out_valid 0, MduResult 0, Stall 0, in_ready 1, latched operands 0.
REQ-031 SHALL keep Operation and BranchInvert purely combinational and unaffected by reset.

Verification
REQ-032 SHALL cover decode sweep: all ALUOp/Funct3/Funct7/IsRType combos -> Operation per REQ-015..018 (e.g. I-type Funct3=000 Funct7=0100000 -> ADD).
REQ-033 SHALL cover WIDTH=32 MULH SrcA=0x80000000 SrcB=0x80000000 -> MduResult 0x40000000, out_valid 33 cycles after accept.
REQ-034 SHALL cover DIV SrcA=-7 SrcB=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-035 SHALL cover DIVU by zero -> 0xFFFFFFFF next cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 next cycle.
REQ-036 SHALL cover reset asserted at BUSY cycle 10 -> out_valid never pulses, in_ready=1 immediately, following MUL 6*7 -> 42.
REQ-037 SHALL cover in_valid held high through BUSY with changing SrcA -> single result from latched operands, in_ready 0 until IDLE.

Source files
------------

// File: rtl/alu_mdu_controller.sv
// ALU operation decoder plus an iterative multiply/divide unit (one shift-add or
// restoring-subtract step per cycle, sign fix-up in a final cycle).
module alu_mdu_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       ALUOp,
   input  logic [6:0]       Funct7,
   input  logic [2:0]       Funct3,
   input  logic             IsRType,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       Operation,
   output logic             BranchInvert,
   output logic             Stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] MduResult
);

   // state  | meaning
   // IDLE   | waiting for a request; only state with in_ready=1
   // BUSY   | WIDTH multiply/divide iteration steps
   // FIX    | sign correction and result select
   // DONE   | out_valid pulse, result registered
   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_SLL    = 4'b0010;
   localparam logic [3:0] OP_SLT    = 4'b0011;
   localparam logic [3:0] OP_SLTU   = 4'b0100;
   localparam logic [3:0] OP_XOR    = 4'b0101;
   localparam logic [3:0] OP_SRL    = 4'b0110;
   localparam logic [3:0] OP_SRA    = 4'b0111;
   localparam logic [3:0] OP_OR     = 4'b1000;
   localparam logic [3:0] OP_AND    = 4'b1001;
   localparam logic [3:0] OP_PASSB  = 4'b1010;
   localparam logic [3:0] OP_CMPEQ  = 4'b1100;
   localparam logic [3:0] OP_CMPLT  = 4'b1101;
   localparam logic [3:0] OP_CMPLTU = 4'b1110;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op;
   logic             neg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] result;
   logic             valid_r;

   logic             is_mdu;
   logic             accept;
   logic             a_signed, b_signed, neg_in;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero, div_ovf;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_shift;
   logic             no_borrow;
   logic [WIDTH-1:0] diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] div_sel, fix_result;

   assign is_mdu       = (ALUOp == 2'b10) && IsRType && (Funct7 == 7'b0000001);
   assign BranchInvert = (ALUOp == 2'b01) && Funct3[0];

   always_comb begin
      Operation = OP_ADD;
      case (ALUOp)
         2'b00: Operation = OP_ADD;
         2'b11: Operation = OP_PASSB;
         2'b01: begin
            case (Funct3[2:1])
               2'b00:   Operation = OP_CMPEQ;
               2'b10:   Operation = OP_CMPLT;
               2'b11:   Operation = OP_CMPLTU;
               default: Operation = OP_ADD;
            endcase
         end
         default: begin
            if (!is_mdu) begin
               case (Funct3)
                  3'b000:  Operation = (IsRType && Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                  3'b001:  Operation = OP_SLL;
                  3'b010:  Operation = OP_SLT;
                  3'b011:  Operation = OP_SLTU;
                  3'b100:  Operation = OP_XOR;
                  3'b101:  Operation = (Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                  3'b110:  Operation = OP_OR;
                  default: Operation = OP_AND;
               endcase
            end
         end
      endcase
   end

   // Operands are converted to magnitudes at accept; neg records the result sign flip.
   assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
   assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100);
   assign mag_a    = (a_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign mag_b    = ((b_signed || Funct3 == 3'b110) && SrcB[WIDTH-1]) ? -SrcB : SrcB;
   assign neg_in   = (a_signed && SrcA[WIDTH-1]) ^ (b_signed && SrcB[WIDTH-1]);
   assign div_zero = Funct3[2] && (SrcB == '0);
   assign div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == MOST_NEG) && (SrcB == '1);
   assign accept   = (state == IDLE) && in_valid && is_mdu;

   assign sum       = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
   assign rem_shift = {acc, lo[WIDTH-1]};
   assign no_borrow = rem_shift >= {1'b0, mcand};
   assign diff      = rem_shift[WIDTH-1:0] - mcand;

   assign prod     = {acc, lo};
   assign prod_fix = neg ? -prod : prod;
   assign div_sel  = op[1] ? acc : lo;

   always_comb begin
      fix_result = '0;
      if (op[2])
         fix_result = neg ? -div_sel : div_sel;
      else if (op[1:0] == 2'b00)
         fix_result = prod_fix[WIDTH-1:0];
      else
         fix_result = prod_fix[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op      <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         lo      <= '0;
         mcand   <= '0;
         result  <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op    <= Funct3;
                  neg   <= neg_in;
                  acc   <= '0;
                  lo    <= mag_a;
                  mcand <= mag_b;
                  cnt   <= CW'(WIDTH - 1);
                  if (div_zero) begin
                     result  <= Funct3[1] ? SrcA : '1;
                     valid_r <= 1'b1;
                     state   <= DONE;
                  end else if (div_ovf) begin
                     result  <= Funct3[1] ? '0 : MOST_NEG;
                     valid_r <= 1'b1;
                     state   <= DONE;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (op[2]) begin
                  acc <= no_borrow ? diff : rem_shift[WIDTH-1:0];
                  lo  <= {lo[WIDTH-2:0], no_borrow};
               end else begin
                  acc <= sum[WIDTH:1];
                  lo  <= {sum[0], lo[WIDTH-1:1]};
               end
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - 1'b1;
            end
            FIX: begin
               result  <= fix_result;
               valid_r <= 1'b1;
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign Stall     = (state == BUSY) || (state == FIX) || accept;
   assign out_valid = valid_r;
   assign MduResult = result;

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Bench for alu_mdu_controller: decode sweep plus scoreboarded multiply/divide
// requests, special cases, mid-operation reset and held-valid behaviour.
module tb_alu_mdu_controller;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    ALUOp;
   logic [6:0]    Funct7;
   logic [2:0]    Funct3;
   logic          IsRType;
   logic [W-1:0]  SrcA, SrcB;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    Operation;
   logic          BranchInvert;
   logic          Stall;
   logic          out_valid;
   logic [W-1:0]  MduResult;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] sb[$];

   alu_mdu_controller #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
      .IsRType(IsRType), .SrcA(SrcA), .SrcB(SrcB), .in_valid(in_valid),
      .in_ready(in_ready), .Operation(Operation), .BranchInvert(BranchInvert),
      .Stall(Stall), .out_valid(out_valid), .MduResult(MduResult)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_op(input logic [1:0] aluop, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic isr);
      case (aluop)
         2'b00: return 4'b0000;
         2'b11: return 4'b1010;
         2'b01: begin
            case (f3[2:1])
               2'b00:   return 4'b1100;
               2'b01:   return 4'b0000;
               2'b10:   return 4'b1101;
               default: return 4'b1110;
            endcase
         end
         default: begin
            if (isr && f7 == 7'b0000001) return 4'b0000;
            case (f3)
               3'd0:    return (isr && f7 == 7'b0100000) ? 4'b0001 : 4'b0000;
               3'd1:    return 4'b0010;
               3'd2:    return 4'b0011;
               3'd3:    return 4'b0100;
               3'd4:    return 4'b0101;
               3'd5:    return (f7 == 7'b0100000) ? 4'b0111 : 4'b0110;
               3'd6:    return 4'b1000;
               default: return 4'b1001;
            endcase
         end
      endcase
   endfunction

   function automatic logic [W-1:0] mdu_model(input logic [2:0] f3, input logic [W-1:0] a, b);
      longint sa = longint'($signed(a));
      longint sbv = longint'($signed(b));
      longint ua = {32'b0, a};
      longint ub = {32'b0, b};
      longint p;
      logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sbv; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sbv; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3, input logic [W-1:0] a, b);
      if (f3[2] && b == 0) return 0;
      if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return W + 1;
   endfunction

   // Scoreboard: every out_valid pulse must match the oldest pushed expectation.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid got=%h expected no pulse", MduResult);
         end else begin
            logic [W-1:0] e;
            e = sb.pop_front();
            if (MduResult !== e) begin
               errors++;
               $display("FAIL mdu_result got=%h expected=%h", MduResult, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog simulation did not finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   task automatic drive_mdu(input logic [2:0] f3, input logic [W-1:0] a, b);
      ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'b0000001;
      Funct3 = f3; SrcA = a; SrcB = b; in_valid = 1'b1;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, b);
      int lat;
      int exp_lat;
      logic stall_bad;
      logic [W-1:0] expv;
      expv = mdu_model(f3, a, b);
      exp_lat = exp_latency(f3, a, b);
      @(negedge clk);
      drive_mdu(f3, a, b);
      #1;
      checks++;
      if (in_ready !== 1'b1 || Stall !== 1'b1) begin
         errors++;
         $display("FAIL accept_handshake in_ready=%b stall=%b expected 1 1", in_ready, Stall);
      end
      sb.push_back(expv);
      @(posedge clk); #1;
      in_valid = 1'b0;
      SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
      lat = 0;
      stall_bad = 1'b0;
      while (out_valid !== 1'b1 && lat < 200) begin
         if (Stall !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency f3=%0d got=%0d expected=%0d", f3, lat, exp_lat);
      end
      checks++;
      if (stall_bad || Stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_busy busy_bad=%b done_stall=%b expected 0 0", stall_bad, Stall);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || MduResult !== expv) begin
         errors++;
         $display("FAIL after_done out_valid=%b in_ready=%b result=%h expected 0 1 %h",
                  out_valid, in_ready, MduResult, expv);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
      IsRType = 1'b0; SrcA = '0; SrcB = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || MduResult !== '0 || in_ready !== 1'b1 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_state out_valid=%b result=%h in_ready=%b stall=%b expected 0 0 1 0",
                  out_valid, MduResult, in_ready, Stall);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      logic [6:0] f7_list [5] = '{7'h00, 7'h20, 7'h01, 7'h7F, 7'h21};
      logic [3:0] e;
      in_valid = 1'b0;
      for (int al = 0; al < 4; al++)
         for (int f3 = 0; f3 < 8; f3++)
            for (int r = 0; r < 2; r++)
               for (int k = 0; k < 5; k++) begin
                  ALUOp = 2'(al); Funct3 = 3'(f3); IsRType = r[0]; Funct7 = f7_list[k];
                  #1;
                  e = exp_op(ALUOp, Funct3, Funct7, IsRType);
                  checks++;
                  if (Operation !== e) begin
                     errors++;
                     $display("FAIL decode aluop=%0d f3=%0d f7=%h r=%0d got=%b expected=%b",
                              al, f3, Funct7, r, Operation, e);
                  end
                  checks++;
                  if (BranchInvert !== (al == 1 && f3[0])) begin
                     errors++;
                     $display("FAIL branch_invert aluop=%0d f3=%0d got=%b expected=%b",
                              al, f3, BranchInvert, (al == 1 && f3[0]));
                  end
               end
   endtask

   task automatic test_mul();
      issue(3'd1, 32'h8000_0000, 32'h8000_0000);
      issue(3'd0, 32'd6, 32'd7);
      issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd1, 32'hFFFF_FFF9, 32'd3);
   endtask

   task automatic test_div();
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2);
      issue(3'd4, 32'd7, 32'hFFFF_FFFE);
      issue(3'd6, 32'd7, 32'hFFFF_FFFE);
      issue(3'd5, 32'hFFFF_FFFF, 32'd10);
      issue(3'd7, 32'hFFFF_FFFF, 32'd10);
   endtask

   task automatic test_div_special();
      issue(3'd5, 32'd1234, 32'd0);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd6, 32'hFFFF_FF00, 32'd0);
      issue(3'd7, 32'd55, 32'd0);
      issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_random();
      logic [2:0] f3;
      logic [W-1:0] a, b;
      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
         issue(f3, a, b);
      end
   endtask

   task automatic test_reset_mid();
      logic pulsed = 1'b0;
      @(negedge clk);
      drive_mdu(3'd0, 32'd100, 32'd200);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      ALUOp = 2'b01; Funct3 = 3'b101;
      #1;
      checks++;
      if (in_ready !== 1'b1 || Stall !== 1'b0 || out_valid !== 1'b0 || MduResult !== '0) begin
         errors++;
         $display("FAIL reset_mid in_ready=%b stall=%b out_valid=%b result=%h expected 1 0 0 0",
                  in_ready, Stall, out_valid, MduResult);
      end
      checks++;
      if (Operation !== 4'b1101 || BranchInvert !== 1'b1) begin
         errors++;
         $display("FAIL decode_in_reset got=%b/%b expected=1101/1", Operation, BranchInvert);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) pulsed = 1'b1;
      end
      checks++;
      if (pulsed) begin
         errors++;
         $display("FAIL reset_abort out_valid pulsed=1 expected 0");
      end
      issue(3'd0, 32'd6, 32'd7);
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic ready_bad = 1'b0;
      @(negedge clk);
      drive_mdu(3'd0, 32'd1000, 32'd3);
      sb.push_back(mdu_model(3'd0, 32'd1000, 32'd3));
      @(posedge clk); #1;
      while (out_valid !== 1'b1 && n < 200) begin
         if (in_ready !== 1'b0) ready_bad = 1'b1;
         SrcA = $urandom;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (ready_bad || n != W + 1) begin
         errors++;
         $display("FAIL held_valid ready_bad=%b latency=%0d expected 0 %0d", ready_bad, n, W + 1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || MduResult !== 32'd3000) begin
         errors++;
         $display("FAIL held_valid_end in_ready=%b result=%h expected 1 %h", in_ready, MduResult, 32'd3000);
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mul();
      test_div();
      test_div_special();
      test_random();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
